// File: rtl/adpll_lock_ctrl.sv
// ADPLL acquisition and lock-supervision sequencer.
// Optional build macro ADPLL_CTRL_AUTO_RETRY_EN: retry acquisition up to 3 times before FAULT.
module adpll_lock_ctrl #(
  parameter int ERROR_WIDTH     = 8,
  parameter int LOCK_THRESH     = 2,
  parameter int LOCK_COUNT      = 16,
  parameter int UNLOCK_COUNT    = 4,
  parameter int SETTLE_PERIODS  = 8,
  parameter int TIMEOUT_PERIODS = 1024,
  parameter int CNT_WIDTH       = 11
) (
  input  logic                          fpga_clk_i,
  input  logic                          reset_i,
  input  logic                          start_i,
  input  logic                          stop_i,
  input  logic                          ref_clk_i,
  input  logic signed [ERROR_WIDTH-1:0] error_i,
  output logic                          pll_enable_o,
  output logic                          pll_reset_o,
  output logic                          locked_o,
  output logic                          timeout_o,
  output logic [2:0]                    state_o,
  output logic [7:0]                    loss_count_o
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RSTP    = 3'd1,
    SETTLE  = 3'd2,
    ACQUIRE = 3'd3,
    LOCKED  = 3'd4,
    FAULT   = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0]   RSTP_LAST   = CNT_WIDTH'(3);
  localparam logic [CNT_WIDTH-1:0]   SETTLE_END  = CNT_WIDTH'(SETTLE_PERIODS);
  localparam logic [CNT_WIDTH-1:0]   LOCK_END    = CNT_WIDTH'(LOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0]   UNLOCK_END  = CNT_WIDTH'(UNLOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0]   TIMEOUT_END = CNT_WIDTH'(TIMEOUT_PERIODS);
  localparam logic [ERROR_WIDTH-1:0] ERR_MIN     = {1'b1, {(ERROR_WIDTH-1){1'b0}}};
  localparam logic [ERROR_WIDTH-1:0] ERR_MAX     = {1'b0, {(ERROR_WIDTH-1){1'b1}}};
  localparam logic [ERROR_WIDTH-1:0] THRESH      = ERROR_WIDTH'(LOCK_THRESH);

  state_t                 state, state_n;
  logic                   ref_s1, ref_s2, ref_d, ref_tick;
  logic [CNT_WIDTH-1:0]   cnt, cnt_n, run, run_n;
  logic [ERROR_WIDTH-1:0] err_u, mag;
  logic                   in_win, loss_inc;
`ifdef ADPLL_CTRL_AUTO_RETRY_EN
  logic [1:0]             retry, retry_n;
`endif

  assign err_u   = $unsigned(error_i);
  assign state_o = state;

  always_comb begin
    if (err_u == ERR_MIN)
      mag = ERR_MAX;
    else if (err_u[ERROR_WIDTH-1])
      mag = ~err_u + 1'b1;
    else
      mag = err_u;
    in_win = (mag <= THRESH);
  end

  // cnt is shared: RSTP cycles, SETTLE ticks, ACQUIRE timeout ticks, LOCKED misses.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    run_n    = run;
    loss_inc = 1'b0;
`ifdef ADPLL_CTRL_AUTO_RETRY_EN
    retry_n  = retry;
`endif
    if (stop_i) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:   if (start_i) state_n = RSTP;
        RSTP:   if (cnt == RSTP_LAST) state_n = SETTLE;
                else cnt_n = cnt + 1'b1;
        SETTLE: if (ref_tick) begin
                  cnt_n = cnt + 1'b1;
                  if (cnt_n == SETTLE_END) state_n = ACQUIRE;
                end
        ACQUIRE: if (ref_tick) begin
                  cnt_n = cnt + 1'b1;
                  run_n = in_win ? run + 1'b1 : '0;
                  if (run_n == LOCK_END) begin
                    state_n = LOCKED;
                  end else if (cnt_n == TIMEOUT_END) begin
`ifdef ADPLL_CTRL_AUTO_RETRY_EN
                    if (retry == 2'd3) begin
                      state_n = FAULT;
                    end else begin
                      state_n = RSTP;
                      retry_n = retry + 1'b1;
                    end
`else
                    state_n = FAULT;
`endif
                  end
                end
        LOCKED: if (ref_tick) begin
                  cnt_n = in_win ? '0 : cnt + 1'b1;
                  if (cnt_n == UNLOCK_END) begin
                    state_n  = ACQUIRE;
                    loss_inc = 1'b1;
                  end
                end
        FAULT:  if (start_i) state_n = RSTP;
        default: state_n = IDLE;
      endcase
    end
    if (state_n != state) begin
      cnt_n = '0;
      run_n = '0;
`ifdef ADPLL_CTRL_AUTO_RETRY_EN
      if (state_n == IDLE || state_n == LOCKED) retry_n = '0;
`endif
    end
  end

  // Outputs decode state_n so they change on the same edge as state_o.
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      state        <= IDLE;
      cnt          <= '0;
      run          <= '0;
      ref_s1       <= 1'b0;
      ref_s2       <= 1'b0;
      ref_d        <= 1'b0;
      ref_tick     <= 1'b0;
      pll_enable_o <= 1'b0;
      pll_reset_o  <= 1'b1;
      locked_o     <= 1'b0;
      timeout_o    <= 1'b0;
      loss_count_o <= '0;
`ifdef ADPLL_CTRL_AUTO_RETRY_EN
      retry        <= '0;
`endif
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      run          <= run_n;
      ref_s1       <= ref_clk_i;
      ref_s2       <= ref_s1;
      ref_d        <= ref_s2;
      ref_tick     <= ref_s2 & ~ref_d;
      pll_enable_o <= (state_n == SETTLE) || (state_n == ACQUIRE) || (state_n == LOCKED);
      pll_reset_o  <= (state_n == IDLE) || (state_n == RSTP) || (state_n == FAULT);
      locked_o     <= (state_n == LOCKED);
      timeout_o    <= (state_n == FAULT);
      if (loss_inc && loss_count_o != '1) loss_count_o <= loss_count_o + 1'b1;
`ifdef ADPLL_CTRL_AUTO_RETRY_EN
      retry        <= retry_n;
`endif
    end
  end
endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// Self-checking bench for adpll_lock_ctrl: directed sequence with randomized errors and
// reference-period lengths, checked against a rule-level model after every reference period.
module tb_adpll_lock_ctrl;
  logic              fpga_clk_i = 1'b0;
  logic              reset_i, start_i, stop_i, ref_clk_i;
  logic signed [7:0] error_i;
  logic              pll_enable_o, pll_reset_o, locked_o, timeout_o;
  logic [2:0]        state_o;
  logic [7:0]        loss_count_o;

  int checks = 0;
  int errors = 0;
  int rstp_seen = 0;

  // Reference model: state code plus the spec-level counters.
  int m_state, m_settle, m_streak, m_acq, m_miss, m_loss, m_retry;

  always #5 fpga_clk_i = ~fpga_clk_i;

  adpll_lock_ctrl #(
    .ERROR_WIDTH(8), .LOCK_THRESH(2), .LOCK_COUNT(16), .UNLOCK_COUNT(4),
    .SETTLE_PERIODS(8), .TIMEOUT_PERIODS(1024), .CNT_WIDTH(11)
  ) dut (
    .fpga_clk_i(fpga_clk_i), .reset_i(reset_i), .start_i(start_i), .stop_i(stop_i),
    .ref_clk_i(ref_clk_i), .error_i(error_i), .pll_enable_o(pll_enable_o),
    .pll_reset_o(pll_reset_o), .locked_o(locked_o), .timeout_o(timeout_o),
    .state_o(state_o), .loss_count_o(loss_count_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_enter(input int s);
    m_state = s; m_settle = 0; m_streak = 0; m_acq = 0; m_miss = 0;
    if (s == 0 || s == 4) m_retry = 0;
  endtask

  task automatic m_reset();
    m_enter(0);
    m_loss = 0;
    m_retry = 0;
  endtask

  task automatic m_tick(input int err);
    int  mag = (err < 0) ? -err : err;
    bit  in_w = (mag <= 2);
    case (m_state)
      2: begin
        m_settle++;
        if (m_settle == 8) m_enter(3);
      end
      3: begin
        m_streak = in_w ? m_streak + 1 : 0;
        m_acq++;
        if (m_streak == 16) m_enter(4);
        else if (m_acq == 1024) begin
`ifdef ADPLL_CTRL_AUTO_RETRY_EN
          if (m_retry == 3) m_enter(5);
          else begin m_retry++; m_enter(1); end
`else
          m_enter(5);
`endif
        end
      end
      4: begin
        m_miss = in_w ? 0 : m_miss + 1;
        if (m_miss == 4) begin
          if (m_loss < 255) m_loss++;
          m_enter(3);
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},   32'(state_o),      32'(m_state));
    chk({tag, ".enable"},  32'(pll_enable_o), 32'(m_state == 2 || m_state == 3 || m_state == 4));
    chk({tag, ".reset"},   32'(pll_reset_o),  32'(m_state == 0 || m_state == 1 || m_state == 5));
    chk({tag, ".locked"},  32'(locked_o),     32'(m_state == 4));
    chk({tag, ".timeout"}, 32'(timeout_o),    32'(m_state == 5));
    chk({tag, ".loss"},    32'(loss_count_o), 32'(m_loss));
  endtask

  function automatic int rnd_in();
    return int'($urandom_range(0, 4)) - 2;
  endfunction

  function automatic int rnd_out();
    int v = int'($urandom_range(3, 128));
    if (v == 128) return -128;
    return ($urandom_range(0, 1) != 0) ? -v : v;
  endfunction

  // One reference period starting and ending just after a falling fpga edge.
  task automatic period(input int err, input string tag);
    int h = int'($urandom_range(2, 3));
    int l = int'($urandom_range(2, 3));
    error_i   = 8'(err);
    ref_clk_i = 1'b1;
    repeat (h) @(negedge fpga_clk_i);
    ref_clk_i = 1'b0;
    repeat (l) @(negedge fpga_clk_i);
    m_tick(err);
    if (m_state == 1) begin
      chk({tag, ".retry_rstp"}, 32'(state_o), 32'd1);
      if (state_o == 3'd1 && pll_reset_o) rstp_seen++;
      repeat (8 - h - l) @(negedge fpga_clk_i);
      m_enter(2);
    end
    check_all(tag);
  endtask

  task automatic do_start();
    start_i = 1'b1;
    @(negedge fpga_clk_i);
    start_i = 1'b0;
    m_enter(1);
    for (int i = 0; i < 4; i++) begin
      chk("rstp.state", 32'(state_o), 32'd1);
      chk("rstp.reset", 32'(pll_reset_o), 32'd1);
      chk("rstp.enable", 32'(pll_enable_o), 32'd0);
      @(negedge fpga_clk_i);
    end
    m_enter(2);
    check_all("settle_entry");
  endtask

  initial begin
    int acq_ticks;
    reset_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; ref_clk_i = 1'b0; error_i = '0;
    m_reset();
    repeat (2) @(negedge fpga_clk_i);
    check_all("reset");
    reset_i = 1'b0;
    @(negedge fpga_clk_i);
    check_all("idle");

    do_start();
    for (int i = 0; i < 8; i++) period(0, "settle");
    for (int i = 0; i < 15; i++) period(0, "acq_zero");
    period(5, "acq_break");
    for (int i = 0; i < 16; i++) period(rnd_in(), "acq_streak");
    chk("lock_after_streak", 32'(locked_o), 32'd1);

    for (int i = 0; i < 4; i++) period(-128, "lose");
    chk("lose.locked", 32'(locked_o), 32'd0);
    chk("lose.state", 32'(state_o), 32'd3);
    chk("lose.count", 32'(loss_count_o), 32'd1);
    for (int i = 0; i < 16; i++) period(0, "relock");
    for (int i = 0; i < 3; i++) period(rnd_out(), "miss3");
    period(rnd_in(), "miss_clear");
    chk("three_misses_keep_lock", 32'(locked_o), 32'd1);

    for (int i = 0; i < 200; i++)
      period(($urandom_range(0, 9) < 7) ? rnd_in() : rnd_out(), "random");

    for (int i = 0; i < 40 && m_state != 4; i++) period(rnd_in(), "to_lock");
    stop_i = 1'b1; start_i = 1'b1;
    @(negedge fpga_clk_i);
    stop_i = 1'b0; start_i = 1'b0;
    m_enter(0);
    check_all("stop_over_start");

    do_start();
    for (int i = 0; i < 8; i++) period(rnd_in(), "settle2");
    for (int i = 0; i < 5; i++) period(rnd_in(), "acq2");
    reset_i = 1'b1;
    @(negedge fpga_clk_i);
    m_reset();
    check_all("reset_mid_acq");
    reset_i = 1'b0;
    @(negedge fpga_clk_i);
    check_all("after_reset");

    do_start();
    acq_ticks = 0;
    rstp_seen = 0;
    for (int i = 0; i < 6000 && !timeout_o; i++) begin
      if (state_o == 3'd3) acq_ticks++;
      period(20, "timeout");
    end
    chk("timeout.flag", 32'(timeout_o), 32'd1);
    chk("timeout.enable", 32'(pll_enable_o), 32'd0);
    chk("timeout.state", 32'(state_o), 32'd5);
`ifdef ADPLL_CTRL_AUTO_RETRY_EN
    chk("timeout.acq_ticks", 32'(acq_ticks), 32'd4096);
    chk("timeout.rstp_reentries", 32'(rstp_seen), 32'd3);
`else
    chk("timeout.acq_ticks", 32'(acq_ticks), 32'd1024);
    chk("timeout.rstp_reentries", 32'(rstp_seen), 32'd0);
`endif
    do_start();

    reset_i = 1'b1;
    @(negedge fpga_clk_i);
    reset_i = 1'b0;
    m_reset();
    @(negedge fpga_clk_i);
    do_start();
    for (int i = 0; i < 8; i++) period(rnd_in(), "settle3");
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < 16; i++) period(rnd_in(), "sat_lock");
      for (int i = 0; i < 4; i++) period(rnd_out(), "sat_lose");
    end
    chk("loss_saturated", 32'(loss_count_o), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
